// File: rtl/framer_pkg.sv
// Shared defaults and FSM state encoding for the overlapping frame extractor.
package framer_pkg;

    localparam int DEF_BIT_WIDTH   = 32;
    localparam int DEF_WINDOW_SIZE = 400;
    localparam int DEF_HOP         = 160;
    localparam int DEF_RAM_DEPTH   = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/overlap_framer_if.sv
// Sample stream into the framer and frame stream out towards windowed_fft.
interface overlap_framer_if
    import framer_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
);

    // Handshake: both directions are valid-only strobes with no ready. A sample
    // is accepted on every cycle sample_valid_in is high; the consumer must take
    // sample_out on every cycle sample_valid_out is high, with no backpressure.
    logic signed [BIT_WIDTH-1:0] sample_in;
    logic                        sample_valid_in;
    logic signed [BIT_WIDTH-1:0] sample_out;
    logic                        sample_valid_out;
    logic                        frame_first_out;
    logic                        frame_last_out;
    logic                        busy_out;
    logic                        overrun_out;

    modport master (
        output sample_in, sample_valid_in,
        input  sample_out, sample_valid_out, frame_first_out, frame_last_out,
               busy_out, overrun_out
    );

    modport slave (
        input  sample_in, sample_valid_in,
        output sample_out, sample_valid_out, frame_first_out, frame_last_out,
               busy_out, overrun_out
    );

endinterface

// File: rtl/ring_ram.sv
// Simple dual-port sample ring: one write port, one synchronous read port.
module ring_ram #(
    parameter int BIT_WIDTH = 32,
    parameter int RAM_DEPTH = 512
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         wr_en,
    input  logic [$clog2(RAM_DEPTH)-1:0] wr_addr,
    input  logic [BIT_WIDTH-1:0]         wr_data,
    input  logic                         rd_en,
    input  logic [$clog2(RAM_DEPTH)-1:0] rd_addr,
    output logic [BIT_WIDTH-1:0]         rd_data
);

    logic [BIT_WIDTH-1:0] mem [RAM_DEPTH];

    // Array is never reset so it maps onto block RAM; only the output register clears.
    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)    rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/overlap_framer.sv
// Writes incoming samples into a ring and replays the newest WINDOW_SIZE of them every HOP samples.
module overlap_framer
    import framer_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    parameter int HOP         = DEF_HOP,
    parameter int RAM_DEPTH   = DEF_RAM_DEPTH
) (
    input  logic            clk_in,
    input  logic            rst_in,
    overlap_framer_if.slave bus,
    output state_t          state_dbg
);

    localparam int PTR_W = $clog2(RAM_DEPTH);
    localparam int CNT_W = $clog2(WINDOW_SIZE + 1);
    localparam int HOP_W = (HOP > 1) ? $clog2(HOP) : 1;

    if (((RAM_DEPTH & (RAM_DEPTH - 1)) != 0) || (RAM_DEPTH < WINDOW_SIZE + 1)) begin : g_bad_depth
        $error("RAM_DEPTH must be a power of two and at least WINDOW_SIZE+1");
    end

    state_t               state;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [HOP_W-1:0]     hop_cnt;
    logic [CNT_W-1:0]     rd_cnt;
    logic                 fill;
    logic                 wrap_q;
    logic                 request;
    logic                 rd_en;
    logic                 valid_q;
    logic                 first_q;
    logic                 last_q;
    logic                 busy;
    logic                 overrun;
    logic [BIT_WIDTH-1:0] ram_q;

    assign request = wrap_q & fill;
    assign rd_en   = (state == EMIT);

    // Fill can key off wr_ptr because the ring is deeper than the window, so
    // wr_ptr reaches WINDOW_SIZE-1 before it ever wraps.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr  <= '0;
            hop_cnt <= '0;
            fill    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (bus.sample_valid_in) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (hop_cnt == HOP_W'(HOP - 1)) begin
                    hop_cnt <= '0;
                    wrap_q  <= 1'b1;
                end else begin
                    hop_cnt <= hop_cnt + HOP_W'(1);
                end
                if (wr_ptr == PTR_W'(WINDOW_SIZE - 1)) fill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            rd_cnt  <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= rd_en;
            first_q <= rd_en && (rd_cnt == CNT_W'(WINDOW_SIZE));
            last_q  <= rd_en && (rd_cnt == CNT_W'(1));
            if (request && (state != IDLE)) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (request) begin
                        state  <= EMIT;
                        rd_ptr <= wr_ptr - PTR_W'(WINDOW_SIZE);
                        rd_cnt <= CNT_W'(WINDOW_SIZE);
                        busy   <= 1'b1;
                    end
                end
                EMIT: begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    rd_cnt <= rd_cnt - CNT_W'(1);
                    // busy clears here so it is already low while the last sample is out.
                    if (rd_cnt == CNT_W'(1)) begin
                        state <= FLUSH;
                        busy  <= 1'b0;
                    end
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    ring_ram #(
        .BIT_WIDTH(BIT_WIDTH),
        .RAM_DEPTH(RAM_DEPTH)
    ) u_ram (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .wr_en   (bus.sample_valid_in),
        .wr_addr (wr_ptr),
        .wr_data (bus.sample_in),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    assign bus.sample_out       = ram_q;
    assign bus.sample_valid_out = valid_q;
    assign bus.frame_first_out  = first_q;
    assign bus.frame_last_out   = last_q;
    assign bus.busy_out         = busy;
    assign bus.overrun_out      = overrun;
    assign state_dbg            = state;

endmodule

// File: tb/tb_overlap_framer.sv
// Directed bench for overlap_framer: default-parameter instance plus a HOP=100 instance for overrun.
module tb_overlap_framer;
    import framer_pkg::*;

    localparam int WIN = 400;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   rst2_n;
    state_t st1;
    state_t st2;
    int     cyc = 0;
    int     last_in_cyc = 0;
    int     tests = 0;
    int     fails = 0;

    logic [31:0] got_v[$];
    bit          got_first[$];
    bit          got_last[$];
    bit          got_busy[$];
    int          got_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    overlap_framer_if #(.BIT_WIDTH(32)) bus ();
    overlap_framer_if #(.BIT_WIDTH(32)) bus2 ();

    overlap_framer #(.BIT_WIDTH(32), .WINDOW_SIZE(400), .HOP(160), .RAM_DEPTH(512)) u_dut (
        .clk_in(clk), .rst_in(rst_n), .bus(bus), .state_dbg(st1)
    );

    overlap_framer #(.BIT_WIDTH(32), .WINDOW_SIZE(400), .HOP(100), .RAM_DEPTH(512)) u_dut2 (
        .clk_in(clk), .rst_in(rst2_n), .bus(bus2), .state_dbg(st2)
    );

    always @(negedge clk) begin
        if (bus.sample_valid_out) begin
            got_v.push_back(bus.sample_out);
            got_first.push_back(bus.frame_first_out);
            got_last.push_back(bus.frame_last_out);
            got_busy.push_back(bus.busy_out);
            got_cyc.push_back(cyc);
        end else if (bus2.sample_valid_out) begin
            got_v.push_back(bus2.sample_out);
            got_first.push_back(bus2.frame_first_out);
            got_last.push_back(bus2.frame_last_out);
            got_busy.push_back(bus2.busy_out);
            got_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        got_v.delete(); got_first.delete(); got_last.delete();
        got_busy.delete(); got_cyc.delete();
    endtask

    task automatic send(input int which, input int v, input int gap);
        @(negedge clk);
        if (which == 1) begin
            bus.sample_in = v; bus.sample_valid_in = 1'b1;
        end else begin
            bus2.sample_in = v; bus2.sample_valid_in = 1'b1;
        end
        last_in_cyc = cyc;
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
        bus2.sample_valid_in = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic wait_entries(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_v.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
    endtask

    // Counts deviations of one logged frame from the expected run lo..lo+WIN-1.
    function automatic int frame_errors(input int base, input int lo);
        int e = 0;
        if (got_v.size() < base + WIN) return WIN;
        for (int i = 0; i < WIN; i++) begin
            if (got_v[base+i] !== 32'(lo + i)) e++;
            if (got_first[base+i] !== (i == 0)) e++;
            if (got_last[base+i] !== (i == WIN - 1)) e++;
            if (got_busy[base+i] !== (i != WIN - 1)) e++;
            if (got_cyc[base+i] != got_cyc[base] + i) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        bus.sample_in = '0; bus.sample_valid_in = 1'b0;
        bus2.sample_in = '0; bus2.sample_valid_in = 1'b0;
        rst_n = 1'b0; rst2_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus.sample_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.sample_valid_out); end
        tests++; if (bus.frame_first_out !== 1'b0 || bus.frame_last_out !== 1'b0) begin fails++; $display("FAIL reset_first_last: got %b%b want 00", bus.frame_first_out, bus.frame_last_out); end
        tests++; if (bus.busy_out !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
        tests++; if (bus.overrun_out !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", bus.overrun_out); end
        tests++; if (bus.sample_out !== 32'sd0) begin fails++; $display("FAIL reset_sample: got %0h want 0", bus.sample_out); end
        tests++; if (st1 !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", st1, IDLE); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_frame();
        bit ok;
        int wrap;
        clear_log();
        for (int v = 1; v <= 479; v++) send(1, v, 20);
        tests++; if (got_v.size() != 0) begin fails++; $display("FAIL f1_no_early_frame: got %0d entries want 0", got_v.size()); end
        send(1, 480, 20);
        wrap = last_in_cyc;
        wait_entries(WIN, 1000, ok);
        tests++; if (!ok || got_v.size() != WIN) begin fails++; $display("FAIL f1_count: got %0d want %0d", got_v.size(), WIN); end
        tests++; if (frame_errors(0, 81) != 0) begin fails++; $display("FAIL f1_content: got %0d bad fields want 0", frame_errors(0, 81)); end
        tests++; if (got_cyc.size() == 0 || got_cyc[0] - wrap != 3) begin fails++; $display("FAIL f1_latency: got %0d want 3", (got_cyc.size() > 0) ? got_cyc[0] - wrap : -1); end
        tests++; if (bus.overrun_out !== 1'b0 || bus.busy_out !== 1'b0 || st1 !== IDLE) begin fails++; $display("FAIL f1_after: got ovr=%b busy=%b st=%0d want 0 0 0", bus.overrun_out, bus.busy_out, st1); end
    endtask

    task automatic test_second_frame_emit_write();
        bit ok;
        int wrap;
        int n = 0;
        clear_log();
        for (int v = 481; v <= 639; v++) send(1, v, 20);
        tests++; if (got_v.size() != 0) begin fails++; $display("FAIL f2_between_frames: got %0d entries want 0", got_v.size()); end
        send(1, 640, 2);
        wrap = last_in_cyc;
        for (int i = 0; i < 600 && n < 100; i++) begin
            @(posedge clk); #2;
            if (st1 == EMIT) n++;
        end
        tests++; if (n != 100) begin fails++; $display("FAIL f2_emit_reach: got %0d emit cycles want 100", n); end
        send(1, 641, 20);
        wait_entries(WIN, 1000, ok);
        tests++; if (!ok || got_v.size() != WIN) begin fails++; $display("FAIL f2_count: got %0d want %0d", got_v.size(), WIN); end
        tests++; if (frame_errors(0, 241) != 0) begin fails++; $display("FAIL f2_content: got %0d bad fields want 0", frame_errors(0, 241)); end
        tests++; if (got_cyc.size() == 0 || got_cyc[0] - wrap != 3) begin fails++; $display("FAIL f2_latency: got %0d want 3", (got_cyc.size() > 0) ? got_cyc[0] - wrap : -1); end
        tests++; if (bus.overrun_out !== 1'b0) begin fails++; $display("FAIL f2_overrun: got %b want 0", bus.overrun_out); end
    endtask

    task automatic test_third_frame();
        bit ok;
        int wrap;
        clear_log();
        for (int v = 642; v <= 799; v++) send(1, v, 20);
        send(1, 800, 20);
        wrap = last_in_cyc;
        wait_entries(WIN, 1000, ok);
        tests++; if (!ok || got_v.size() != WIN) begin fails++; $display("FAIL f3_count: got %0d want %0d", got_v.size(), WIN); end
        tests++; if (frame_errors(0, 401) != 0) begin fails++; $display("FAIL f3_content: got %0d bad fields want 0", frame_errors(0, 401)); end
        tests++; if (got_cyc.size() == 0 || got_cyc[0] - wrap != 3) begin fails++; $display("FAIL f3_latency: got %0d want 3", (got_cyc.size() > 0) ? got_cyc[0] - wrap : -1); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n = 0;
        clear_log();
        for (int v = 801; v <= 959; v++) send(1, v, 20);
        send(1, 960, 2);
        for (int i = 0; i < 1000 && n < 200; i++) begin
            @(posedge clk); #2;
            if (bus.sample_valid_out) n++;
        end
        tests++; if (n != 200) begin fails++; $display("FAIL rst_mid_reach: got %0d valid cycles want 200", n); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.sample_valid_out !== 1'b0 || bus.frame_first_out !== 1'b0 || bus.frame_last_out !== 1'b0) begin fails++; $display("FAIL rst_mid_flags: got v=%b f=%b l=%b want 0 0 0", bus.sample_valid_out, bus.frame_first_out, bus.frame_last_out); end
        tests++; if (bus.busy_out !== 1'b0 || bus.overrun_out !== 1'b0) begin fails++; $display("FAIL rst_mid_busy_ovr: got %b %b want 0 0", bus.busy_out, bus.overrun_out); end
        tests++; if (bus.sample_out !== 32'sd0) begin fails++; $display("FAIL rst_mid_sample: got %0h want 0", bus.sample_out); end
        tests++; if (st1 !== IDLE) begin fails++; $display("FAIL rst_mid_state: got %0d want %0d", st1, IDLE); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        for (int v = 1; v <= 479; v++) send(1, 1000 + v, 4);
        repeat (30) @(negedge clk);
        tests++; if (got_v.size() != 0) begin fails++; $display("FAIL rst_no_frame_479: got %0d entries want 0", got_v.size()); end
        send(1, 1480, 4);
        wait_entries(WIN, 1000, ok);
        tests++; if (!ok || got_v.size() != WIN) begin fails++; $display("FAIL rst_frame_count: got %0d want %0d", got_v.size(), WIN); end
        tests++; if (frame_errors(0, 1081) != 0) begin fails++; $display("FAIL rst_frame_content: got %0d bad fields want 0", frame_errors(0, 1081)); end
    endtask

    task automatic test_overrun();
        bit ok;
        @(negedge clk);
        rst2_n = 1'b1;
        clear_log();
        for (int v = 1; v <= 499; v++) send(2, v, 4);
        tests++; if (bus2.overrun_out !== 1'b0) begin fails++; $display("FAIL ovr_before: got %b want 0", bus2.overrun_out); end
        for (int v = 500; v <= 600; v++) send(2, v, 4);
        wait_entries(2 * WIN, 2000, ok);
        tests++; if (!ok || got_v.size() != 2 * WIN) begin fails++; $display("FAIL ovr_count: got %0d want %0d", got_v.size(), 2 * WIN); end
        tests++; if (frame_errors(0, 1) != 0) begin fails++; $display("FAIL ovr_frame1: got %0d bad fields want 0", frame_errors(0, 1)); end
        tests++; if (frame_errors(WIN, 201) != 0) begin fails++; $display("FAIL ovr_frame2: got %0d bad fields want 0", frame_errors(WIN, 201)); end
        tests++; if (bus2.overrun_out !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", bus2.overrun_out); end
        repeat (50) @(negedge clk);
        tests++; if (bus2.overrun_out !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", bus2.overrun_out); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame_emit_write();
        test_third_frame();
        test_reset_mid_frame();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #800000;
        tests++;
        fails++;
        $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
